// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
// 8N1 UART receiver with a two-flop input synchroniser and a 3-sample majority
// vote per bit. A start bit that is not held low at mid-bit is rejected as a glitch.
// A low stop bit raises one frame_err pulse. The receiver then waits for the line
// to return high, so a break condition reports only once. Received bytes go into a
// small first-word-fall-through FIFO that the consumer drains with rd_en.

module uart_rx_oversample #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rxout,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FCNT_W  = PTR_W + 1;
  localparam int HALF    = CLKS_PER_BIT / 2;

  // The three vote samples straddle mid-bit; the vote is resolved on the last one.
  localparam logic [CNT_W-1:0]  SAMPLE_A   = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_B   = CNT_W'(HALF);
  localparam logic [CNT_W-1:0]  SAMPLE_C   = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FULL_COUNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // Two-of-three vote used for every bit decision.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic              rx_meta_q, rx_meta_d;
  logic              rx_sync_q, rx_sync_d;
  logic              rx_s;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              samp_a_q, samp_a_d;
  logic              samp_b_q, samp_b_d;
  logic [7:0]        shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              rx_busy_q, rx_busy_d;
  logic              maj_s;
  logic              push_s;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic [7:0]        rxout_q, rxout_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              full_s;
  logic              pop_s;
  logic              wr_en_s;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------

  // Next values for the two synchroniser stages.
  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
  end

  // Synchroniser flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
    end
  end

  assign rx_s  = rx_sync_q;
  assign maj_s = majority3(samp_a_q, samp_b_q, rx_s);

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------

  // Next-state, bit timing, sampling and the stop-bit decision.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    samp_a_d    = samp_a_q;
    samp_b_d    = samp_b_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push_s      = 1'b0;

    if (cnt_q == SAMPLE_A) begin
      samp_a_d = rx_s;
    end else if (cnt_q == SAMPLE_B) begin
      samp_b_d = rx_s;
    end else begin
      samp_a_d = samp_a_q;
      samp_b_d = samp_b_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if ((cnt_q == SAMPLE_C) && maj_s) begin
          // Line went back high before mid-bit: treat as noise.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = ST_DATA;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == SAMPLE_C) begin
          shift_d = {maj_s, shift_q[7:1]};
        end else begin
          shift_d = shift_q;
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        // Decide at mid stop bit and leave at once so an early next start is seen.
        if (cnt_q == SAMPLE_C) begin
          cnt_d = '0;
          if (maj_s) begin
            push_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    rx_busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
  end

  // FSM state, bit timing and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      samp_a_q    <= 1'b1;
      samp_b_q    <= 1'b1;
      shift_q     <= 8'h00;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      samp_a_q    <= samp_a_d;
      samp_b_q    <= samp_b_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      rx_busy_q   <= rx_busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Received-byte FIFO (first word fall through)
  // ---------------------------------------------------------------------------

  // Push/pop arbitration, pointer and count update, next head byte.
  always_comb begin
    full_s    = (count_q == FULL_COUNT);
    pop_s     = rd_en && rx_valid_q;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    wr_en_s   = push_s && (!full_s || pop_s);
    overrun_d = push_s && full_s && !pop_s;

    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = shift_q;
    end else begin
      mem_d = mem_q;
    end

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase

    rx_valid_d = (count_d != '0);

    // The incoming byte becomes the head when it lands in the slot the read pointer moves to.
    if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
      rxout_d = shift_q;
    end else begin
      rxout_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage, pointers and registered FIFO outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '{default: 8'h00};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rxout_q    <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rxout_q    <= rxout_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rxout      = rxout_q;
  assign rx_valid   = rx_valid_q;
  assign fifo_count = count_q;
  assign rx_busy    = rx_busy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
